// File: rtl/ibus_lane_receiver_pkg.sv
// Shared types for the two-lane iBus receiver.
// Lane FSM states, lane index type and frame length helper.
package ibus_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    BREAK
  } lane_state_e;

  typedef logic [0:0] lane_t;

  function automatic int frame_bits(input int data_w);
    return data_w + 3;
  endfunction

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_BITS = frame_bits(DATA_W_DEF);

endpackage

// File: rtl/ibus_lane_receiver_if.sv
// Merged word stream leaving the receiver.
// master drives data/lane/valid, slave returns ready.
interface ibus_lane_receiver_if #(
  parameter int DATA_W = 8
);
  import ibus_rx_pkg::*;

  logic [DATA_W-1:0] m_data;
  lane_t             m_lane;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_lane,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_lane,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/ibus_lane_deser.sv
// One-lane frame deserialiser: start, LSB-first data,
// even parity, stop; result pulses one cycle after stop.
module ibus_lane_deser
  import ibus_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] word,
  output logic              word_good,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int CW = $clog2(frame_bits(DATA_W));
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  lane_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sr_q;
  logic              par_ok_q;

  assign word = sr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!rx) state_d = DATA;
      DATA:    if (cnt_q == LAST) state_d = PARITY;
      PARITY:  state_d = STOP;
      STOP:    state_d = rx ? IDLE : BREAK;
      BREAK:   if (rx) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      par_ok_q   <= 1'b0;
      word_good  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_good  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state_q)
        IDLE: cnt_q <= '0;
        DATA: begin
          sr_q  <= {rx, sr_q[DATA_W-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
        PARITY: par_ok_q <= ~(^sr_q ^ rx);
        // A bad stop bit wins over a parity mismatch
        STOP: begin
          if (rx) begin
            word_good  <= par_ok_q;
            parity_err <= ~par_ok_q;
          end else begin
            frame_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ibus_lane_receiver.sv
// Two-lane iBus receiver: per-lane hold registers,
// round-robin merge onto one stream, error counting.
module ibus_lane_receiver
  import ibus_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:1]           ibus,
  ibus_lane_receiver_if.master m,
  output logic [0:1]           parity_err,
  output logic [0:1]           frame_err,
  output logic [0:1]           overrun,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] word [2];
  logic [1:0]        good;
  logic [DATA_W-1:0] hold_data [2];
  logic [1:0]        hold_v;
  logic [1:0]        drain;
  lane_t             grant;
  lane_t             rr_q;
  lane_t             lock_lane_q;
  logic              lock_q;
  logic              accept;
  logic [CNT_W:0]    err_sum;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    ibus_lane_deser #(
      .DATA_W(DATA_W)
    ) u_deser (
      .clk       (clk),
      .rst       (rst),
      .rx        (ibus[g]),
      .word      (word[g]),
      .word_good (good[g]),
      .parity_err(parity_err[g]),
      .frame_err (frame_err[g])
    );
  end

  // A stalled grant stays put even if the other lane fills
  always_comb begin
    grant = 1'b0;
    if (lock_q) grant = lock_lane_q;
    else if (&hold_v) grant = rr_q;
    else if (hold_v[1]) grant = 1'b1;
  end

  assign m.m_valid = |hold_v;
  assign m.m_data  = hold_data[grant];
  assign m.m_lane  = grant;
  assign accept    = m.m_valid & m.m_ready;
  assign drain[0]  = accept & (grant == 1'b0);
  assign drain[1]  = accept & (grant == 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v      <= '0;
      hold_data   <= '{default: '0};
      overrun     <= '0;
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_lane_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        overrun[i] <= 1'b0;
        if (drain[i]) hold_v[i] <= 1'b0;
        if (good[i]) begin
          if (hold_v[i] && !drain[i]) begin
            overrun[i] <= 1'b1;
          end else begin
            hold_v[i]    <= 1'b1;
            hold_data[i] <= word[i];
          end
        end
      end
      if (accept && (&hold_v)) rr_q <= ~grant;
      lock_q      <= m.m_valid & ~m.m_ready;
      lock_lane_q <= grant;
    end
  end

  always_comb begin
    err_sum = {1'b0, err_cnt}
            + (CNT_W+1)'($countones({parity_err, frame_err, overrun}));
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= err_sum[CNT_W] ? CNT_MAX : err_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_ibus_lane_receiver.sv
// Directed bench for ibus_lane_receiver.
// Hand-computed expectations, immediate assertions.
module tb_ibus_lane_receiver;
  import ibus_rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:1] ibus;
  logic [0:1] parity_err;
  logic [0:1] frame_err;
  logic [0:1] overrun;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int snap_acc;
  int snap_fe;

  ibus_lane_receiver_if #(.DATA_W(8)) bus ();

  ibus_lane_receiver #(
    .DATA_W(8),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ibus      (ibus),
    .m         (bus),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) acc_cnt++;
    fe_cnt += $countones(frame_err);
    ov_cnt += $countones(overrun);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // en/pflip/stop: bit 0 = lane 0, bit 1 = lane 1
  task automatic send2(input logic [1:0] en, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [1:0] pflip,
                       input logic [1:0] stop);
    logic [10:0] f0, f1;
    f0 = {stop[0], ^d0 ^ pflip[0], d0, 1'b0};
    f1 = {stop[1], ^d1 ^ pflip[1], d1, 1'b0};
    for (int b = 0; b < 11; b++) begin
      ibus[0] = en[0] ? f0[b] : 1'b1;
      ibus[1] = en[1] ? f1[b] : 1'b1;
      step();
    end
    ibus = 2'b11;
  endtask

  initial begin
    rst = 1'b1;
    ibus = 2'b11;
    bus.m_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_lane", bus.m_lane, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_pulses", {parity_err, frame_err, overrun}, 0);

    bus.m_ready = 1'b1;
    send2(2'b01, 8'hA5, 8'h00, 2'b00, 2'b11);
    chk("a5_early", bus.m_valid, 0);
    step();
    chk("a5_valid", bus.m_valid, 1);
    chk("a5_data", bus.m_data, 8'hA5);
    chk("a5_lane", bus.m_lane, 0);
    step();
    chk("a5_gone", bus.m_valid, 0);

    send2(2'b11, 8'h11, 8'h22, 2'b00, 2'b11);
    step();
    chk("p1_data0", bus.m_data, 8'h11);
    chk("p1_lane0", bus.m_lane, 0);
    step();
    chk("p1_data1", bus.m_data, 8'h22);
    chk("p1_lane1", bus.m_lane, 1);
    step();
    chk("p1_empty", bus.m_valid, 0);
    send2(2'b11, 8'h33, 8'h44, 2'b00, 2'b11);
    step();
    chk("p2_data0", bus.m_data, 8'h44);
    chk("p2_lane0", bus.m_lane, 1);
    step();
    chk("p2_data1", bus.m_data, 8'h33);
    chk("p2_lane1", bus.m_lane, 0);
    step();
    chk("p2_empty", bus.m_valid, 0);

    snap_acc = acc_cnt;
    send2(2'b10, 8'h00, 8'h3C, 2'b10, 2'b11);
    chk("par_pulse", parity_err, 2'b01);
    step();
    chk("par_cnt", err_cnt, 1);
    chk("par_clear", parity_err, 0);
    repeat (3) step();
    chk("par_nodata", acc_cnt - snap_acc, 0);
    chk("par_novalid", bus.m_valid, 0);

    snap_acc = acc_cnt;
    snap_fe = fe_cnt;
    send2(2'b01, 8'hC3, 8'h00, 2'b00, 2'b10);
    ibus[0] = 1'b0;
    chk("brk_pulse", frame_err, 2'b10);
    repeat (20) step();
    chk("brk_once", fe_cnt - snap_fe, 1);
    chk("brk_nodata", acc_cnt - snap_acc, 0);
    chk("brk_cnt", err_cnt, 2);
    ibus[0] = 1'b1;
    step();
    send2(2'b01, 8'h5A, 8'h00, 2'b00, 2'b11);
    step();
    chk("brk_valid", bus.m_valid, 1);
    chk("brk_data", bus.m_data, 8'h5A);
    chk("brk_lane", bus.m_lane, 0);
    step();

    bus.m_ready = 1'b0;
    send2(2'b01, 8'h01, 8'h00, 2'b00, 2'b11);
    send2(2'b01, 8'h02, 8'h00, 2'b00, 2'b11);
    step();
    chk("ovr_pulse", overrun, 2'b10);
    chk("ovr_valid", bus.m_valid, 1);
    chk("ovr_keep", bus.m_data, 8'h01);
    bus.m_ready = 1'b1;
    step();
    chk("ovr_cnt", err_cnt, 3);
    chk("ovr_dropped", bus.m_valid, 0);

    bus.m_ready = 1'b0;
    send2(2'b01, 8'h01, 8'h00, 2'b00, 2'b11);
    send2(2'b01, 8'h02, 8'h00, 2'b00, 2'b11);
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    chk("drn_noovr", overrun, 0);
    chk("drn_valid", bus.m_valid, 1);
    chk("drn_data", bus.m_data, 8'h02);
    bus.m_ready = 1'b1;
    step();
    chk("drn_empty", bus.m_valid, 0);
    chk("drn_ovtotal", ov_cnt, 1);
    chk("drn_cnt", err_cnt, 3);

    ibus[1] = 1'b0;
    step();
    ibus[1] = 1'b1;
    step();
    ibus[1] = 1'b0;
    step();
    ibus[1] = 1'b1;
    step();
    rst = 1'b1;
    ibus = 2'b11;
    step();
    step();
    rst = 1'b0;
    chk("mid_cnt", err_cnt, 0);
    chk("mid_valid", bus.m_valid, 0);
    chk("mid_data", bus.m_data, 0);
    snap_acc = acc_cnt;
    send2(2'b10, 8'h00, 8'h7E, 2'b00, 2'b11);
    step();
    chk("mid_v7e", bus.m_valid, 1);
    chk("mid_d7e", bus.m_data, 8'h7E);
    chk("mid_l7e", bus.m_lane, 1);
    step();
    chk("mid_count", acc_cnt - snap_acc, 1);
    chk("mid_errs", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
